// File: rtl/set_assoc_wb_cache.sv
// Write-back, write-allocate N-way set-associative data cache with FIFO replacement.
// Latency: hit completes 1 cycle after acceptance; miss is 2 + BLK_WORDS*(1+dirty) cycles with zero-wait memory.
// Backpressure: one request at a time; each memory word waits for mem_ack. CACHE_PERF_CNT_EN adds hit/miss/wb counters.
module set_assoc_wb_cache #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int BLK_WORDS = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);

  localparam int OFF_B = $clog2(BLK_WORDS);
  localparam int IDX_B = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_B - OFF_B;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = (OFF_B > 0) ? OFF_B : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL} state_t;
  state_t state, state_nx;

  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [WAY_W-1:0]  fifo_ptr [SETS];
  logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
  logic [DATA_W-1:0] data_arr [SETS][WAYS][BLK_WORDS];

  logic              req_we, missed, victim_fifo;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [WAY_W-1:0]  victim;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic [CNT_W-1:0]  req_off;
  logic [IDX_B-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit_any, inv_any, vic_wb, last;
  logic [WAY_W-1:0]  hit_way, inv_way, vic_way;
  logic [DATA_W-1:0] hit_word;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] t,
                                                input logic [IDX_B-1:0] i,
                                                input logic [CNT_W-1:0] o);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(t) << (IDX_B + OFF_B);
    a = a | (ADDR_W'(i) << OFF_B);
    if (OFF_B > 0) a = a | ADDR_W'(o);
    return a;
  endfunction

  assign req_off  = CNT_W'(req_addr & ADDR_W'(BLK_WORDS - 1));
  assign req_idx  = IDX_B'(req_addr >> OFF_B);
  assign req_tag  = TAG_W'(req_addr >> (OFF_B + IDX_B));
  assign cnt_nx   = cnt + 1'b1;
  assign last     = (cnt == CNT_W'(BLK_WORDS - 1));
  assign vic_way  = inv_any ? inv_way : fifo_ptr[req_idx];
  assign vic_wb   = valid[req_idx][vic_way] && dirty[req_idx][vic_way];
  assign hit_word = data_arr[req_idx][hit_way][req_off];

  // Tag match and lowest-index invalid way for the latched request's set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and CPU-side completion outputs; a refill always ends back in LOOKUP
  always_comb begin
    state_nx  = state;
    cpu_ready = 1'b0;
    hit       = 1'b0;
    cpu_rdata = '0;
    case (state)
      S_IDLE:   if (cpu_req) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (hit_any) begin
          cpu_ready = 1'b1;
          hit       = !missed;
          if (!req_we) cpu_rdata = hit_word;
          state_nx  = S_IDLE;
        end else begin
          state_nx  = vic_wb ? S_WB : S_REFILL;
        end
      end
      S_WB:     if (mem_ack && last) state_nx = S_REFILL;
      S_REFILL: if (mem_ack && last) state_nx = S_LOOKUP;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Request latch, line state, replacement pointers and registered memory port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      missed      <= 1'b0;
      victim      <= '0;
      victim_fifo <= 1'b0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]    <= '0;
        dirty[s]    <= '0;
        fifo_ptr[s] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          missed <= 1'b0;
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            if (req_we) dirty[req_idx][hit_way] <= 1'b1;
          end else begin
            victim      <= vic_way;
            victim_fifo <= !inv_any;
            missed      <= 1'b1;
            cnt         <= '0;
            mem_req     <= 1'b1;
            mem_we      <= vic_wb;
            mem_addr    <= vic_wb ? mk_addr(tag_arr[req_idx][vic_way], req_idx, '0)
                                  : mk_addr(req_tag, req_idx, '0);
            mem_wdata   <= data_arr[req_idx][vic_way][0];
          end
        end
        S_WB: begin
          if (mem_ack) begin
            if (last) begin
              cnt      <= '0;
              mem_we   <= 1'b0;
              mem_addr <= mk_addr(req_tag, req_idx, '0);
            end else begin
              cnt       <= cnt_nx;
              mem_addr  <= mk_addr(tag_arr[req_idx][victim], req_idx, cnt_nx);
              mem_wdata <= data_arr[req_idx][victim][cnt_nx];
            end
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            if (last) begin
              mem_req                <= 1'b0;
              valid[req_idx][victim] <= 1'b1;
              dirty[req_idx][victim] <= 1'b0;
              if (victim_fifo)
                fifo_ptr[req_idx] <= (WAYS > 1) ? fifo_ptr[req_idx] + 1'b1 : '0;
            end else begin
              cnt      <= cnt_nx;
              mem_addr <= mk_addr(req_tag, req_idx, cnt_nx);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: refill words land as they arrive, write hits merge in place
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit_any && req_we)
      data_arr[req_idx][hit_way][req_off] <= req_wdata;
    if (state == S_REFILL && mem_ack) begin
      data_arr[req_idx][victim][cnt] <= mem_rdata;
      if (last) tag_arr[req_idx][victim] <= req_tag;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // Saturating event counters: hit completion, miss completion, written-back block
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == S_LOOKUP && hit_any && !missed && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 1'b1;
      if (state == S_LOOKUP && hit_any && missed && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 1'b1;
      if (state == S_WB && mem_ack && last && wb_cnt != 32'hFFFF_FFFF)
        wb_cnt <= wb_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Directed bench for set_assoc_wb_cache with a line-level cache/memory model and scoreboard.
// Memory responder acks after a programmable number of wait cycles.
// Checks completion data/hit, latency, memory transaction order and request stability.
module tb_set_assoc_wb_cache;
  localparam int ADDR_W = 8, DATA_W = 32, WAYS = 2, SETS = 4, BLK = 2;

  logic clk = 1'b0, rstn = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0, cpu_rdata;
  logic cpu_ready, hit, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata = '0;
  logic mem_ack = 1'b0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  set_assoc_wb_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .BLK_WORDS(BLK)) dut (
    .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit we; int addr; logic [31:0] data; } mtx_t;
  mtx_t exp_q[$];

  logic [31:0] mem   [256];   // responder's memory
  logic [31:0] m_mem [256];   // model's view of memory
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int          m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][BLK];
  int          m_ptr   [SETS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
    end
  endtask

  task automatic model_access(input bit we, input int addr, input logic [31:0] wd,
                              output bit h, output logic [31:0] rd, output bit wb);
    int off, set, tg, way, base;
    bit use_ptr;
    off = addr % BLK;  set = (addr / BLK) % SETS;  tg = addr / (BLK * SETS);
    way = -1;  h = 0;  wb = 0;  rd = '0;
    for (int w = 0; w < WAYS; w++) if (m_valid[set][w] && m_tag[set][w] == tg) way = w;
    if (way >= 0) h = 1;
    else begin
      use_ptr = 1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) begin way = w; use_ptr = 0; end
      if (use_ptr) way = m_ptr[set];
      if (m_valid[set][way] && m_dirty[set][way]) begin
        wb = 1;
        base = (m_tag[set][way] * SETS + set) * BLK;
        for (int o = 0; o < BLK; o++) begin
          exp_q.push_back('{1'b1, base + o, m_data[set][way][o]});
          m_mem[base + o] = m_data[set][way][o];
        end
      end
      base = (tg * SETS + set) * BLK;
      for (int o = 0; o < BLK; o++) begin
        exp_q.push_back('{1'b0, base + o, 32'h0});
        m_data[set][way][o] = m_mem[base + o];
      end
      m_valid[set][way] = 1;  m_dirty[set][way] = 0;  m_tag[set][way] = tg;
      if (use_ptr) m_ptr[set] = (m_ptr[set] + 1) % WAYS;
    end
    if (we) begin m_data[set][way][off] = wd; m_dirty[set][way] = 1; end
    else rd = m_data[set][way][off];
  endtask

  // ---------------- memory responder + port stability checker ----------------
  int ack_delay = 0, wcnt = 0;
  logic prev_req = 0, prev_ack = 0, prev_we = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  // Drive mem_ack in the low phase so it is sampled at the next rising edge
  always @(negedge clk) begin
    mtx_t e;
    if (rstn && prev_req && !prev_ack) begin
      chk("mem_req_hold", mem_req, 1);
      chk("mem_addr_hold", mem_addr, prev_addr);
      chk("mem_we_hold", mem_we, prev_we);
      chk("mem_wdata_hold", mem_wdata, prev_wdata);
    end
    prev_req = mem_req && rstn;  prev_addr = mem_addr;  prev_we = mem_we;  prev_wdata = mem_wdata;
    if (!mem_req || !rstn) begin
      mem_ack = 0;  wcnt = 0;
    end else if (wcnt >= ack_delay) begin
      mem_ack = 1;  wcnt = 0;
      mem_rdata = mem[mem_addr];
      chk("mem_tx_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_tx_we", mem_we, e.we);
        chk("mem_tx_addr", mem_addr, e.addr[ADDR_W-1:0]);
        if (e.we) chk("mem_tx_wdata", mem_wdata, e.data);
      end
      if (mem_we) mem[mem_addr] = mem_wdata;
    end else begin
      mem_ack = 0;  wcnt++;
    end
    prev_ack = mem_ack;
  end

  // ---------------- completion compare ----------------
  bit pending = 0, exp_hit = 0, exp_we = 0;
  logic [31:0] exp_rdata = '0;

  // Every completion pulse must match the model's verdict for the outstanding request
  always @(negedge clk) begin
    if (rstn && cpu_ready) begin
      chk("ready_pending", pending, 1);
      chk("cpu_hit", hit, exp_hit);
      if (!exp_we) chk("cpu_rdata", cpu_rdata, exp_rdata);
      pending = 0;
    end
  end

  task automatic do_req(input bit we, input int addr, input logic [31:0] wd, input int dly,
                        input bit pin, input bit p_hit, input bit p_wb, input logic [31:0] p_rd);
    bit h, wb;
    logic [31:0] rd;
    int lat, exp_lat;
    @(negedge clk);
    ack_delay = dly;
    model_access(we, addr, wd, h, rd, wb);
    if (pin) begin
      chk("model_hit", h, p_hit);
      chk("model_wb", wb, p_wb);
      if (!we) chk("model_rdata", rd, p_rd);
    end
    exp_hit = h;  exp_rdata = rd;  exp_we = we;  pending = 1;
    cpu_req = 1;  cpu_we = we;  cpu_addr = addr[ADDR_W-1:0];  cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 0;  cpu_addr = ~cpu_addr;  cpu_wdata = ~wd;
    lat = 1;
    while (!cpu_ready && lat < 400) begin @(negedge clk); lat++; end
    chk("ready_seen", cpu_ready, 1);
    exp_lat = h ? 1 : 2 + BLK * (1 + int'(wb)) * (1 + dly);
    chk("latency", lat, exp_lat);
    chk("mem_q_drained", exp_q.size(), 0);
  endtask

  initial begin
    int guard;
    for (int a = 0; a < 256; a++) begin mem[a] = a + 32'h100; m_mem[a] = a + 32'h100; end
    model_reset();
    #12;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    rstn = 1;
    @(negedge clk);
    chk("idle_hit", hit, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_cpu_rdata", cpu_rdata, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);

    // 1: cold read miss, then hit in the same block
    do_req(0, 'h10, 0, 0, 1, 0, 0, 32'h110);
    do_req(0, 'h11, 0, 0, 1, 1, 0, 32'h111);
    // 2: dirty the line, fill way1, then evict way0 with a write-back
    do_req(1, 'h10, 32'hDEADBEEF, 0, 1, 1, 0, 0);
    do_req(0, 'h30, 0, 0, 1, 0, 0, 32'h130);
    do_req(0, 'h50, 0, 0, 1, 0, 1, 32'h150);
    chk("wb_mem_10", mem['h10], 32'hDEADBEEF);
    chk("wb_mem_11", mem['h11], 32'h111);
`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    chk("hit_cnt", hit_cnt, 2);
    chk("miss_cnt", miss_cnt, 3);
    chk("wb_cnt", wb_cnt, 1);
`endif
    // 3: write miss allocates without write-back, then read back
    do_req(1, 'h20, 32'h12345678, 0, 1, 0, 0, 0);
    do_req(0, 'h20, 0, 0, 1, 1, 0, 32'h12345678);
    do_req(0, 'h21, 0, 0, 1, 1, 0, 32'h121);
    // 4: slow memory, five wait cycles per word
    do_req(0, 'h02, 0, 5, 1, 0, 0, 32'h102);
    do_req(0, 'h03, 0, 0, 1, 1, 0, 32'h103);

    // 5: reset in the middle of the second refill word
    @(negedge clk);
    ack_delay = 0;
    exp_q.push_back('{1'b0, 'h04, 32'h0});
    exp_q.push_back('{1'b0, 'h05, 32'h0});
    cpu_req = 1;  cpu_we = 0;  cpu_addr = 8'h04;
    @(negedge clk);
    cpu_req = 0;
    guard = 0;
    while (!(mem_req && mem_addr == 8'h05) && guard < 50) begin @(negedge clk); guard++; end
    chk("second_word_seen", mem_addr, 8'h05);
    #2 rstn = 0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_ready", cpu_ready, 0);
    exp_q.delete();
    model_reset();
    pending = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    do_req(0, 'h04, 0, 0, 1, 0, 0, 32'h104);
    do_req(0, 'h05, 0, 0, 1, 1, 0, 32'h105);
    // written-back data survives the reset in memory
    do_req(0, 'h10, 0, 0, 1, 0, 0, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/set_assoc_wb_cache.md
Name: set_assoc_wb_cache

Overview:
Parametrised N-way set-associative data cache between the CPU data port and a handshaked word-wide main memory. Write-back, write-allocate, multi-word blocks, per-set FIFO replacement with invalid-way preference. Replaces the single-cycle write-through 2-way cache. Memory latency is arbitrary and paced by mem_ack.

Parameters:
ADDR_W, 8, word address width
DATA_W, 32, data word width
WAYS, 2, associativity (power of 2, >=1)
SETS, 8, number of sets (power of 2, >=2)
BLK_WORDS, 2, words per block (power of 2, >=1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
cpu_req  in  1  request, sampled in IDLE only
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
hit  out  1  pulses with cpu_ready when the request hit
mem_req  out  1  memory request, held until acked
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completes current word at this edge

Behaviour:
- Reset: rstn is asynchronous and active-low; the clock is clk. All valid/dirty bits and FIFO pointers = 0. State = IDLE. cpu_ready, hit, mem_req, mem_we = 0. cpu_rdata, mem_addr, mem_wdata = 0. Tag and data arrays need not be cleared.
- Address split: offset = low log2(BLK_WORDS) bits; index = next log2(SETS) bits; tag = remaining bits.
- CPU handshake: cpu_req is sampled at a rising edge in IDLE, and addr/we/wdata are latched at that edge. CPU inputs are ignored until cpu_ready pulses. The next request may be presented in the cycle after cpu_ready.
- IDLE -> LOOKUP on cpu_req.
- LOOKUP, hit: cpu_ready=1 and hit=1 for one cycle, so latency is 1 cycle after acceptance. A read drives the word onto cpu_rdata. A write updates the word and sets dirty. No memory access. Return to IDLE.
- LOOKUP, miss: choose the victim as the lowest-index invalid way; otherwise fifo_ptr[index]. If the victim is valid and dirty -> WB, else -> REFILL.
- WB: write BLK_WORDS words, offsets 0..BLK_WORDS-1, to {victim_tag,index,offset} with mem_we=1. Each word completes on mem_ack. mem_req stays high, and address/data for the next word are presented in the cycle after the ack (back-to-back allowed). After the last ack -> REFILL.
- REFILL: read BLK_WORDS words from {tag,index,offset}, ascending, with mem_we=0. Each mem_rdata is captured on its mem_ack. After the last word:
  - Set valid=1, tag, dirty=0.
  - If the victim was chosen by fifo_ptr, advance fifo_ptr[index] mod WAYS.
  - Go to LOOKUP, which now hits: a read returns data; a write merges cpu_wdata and sets dirty. hit=0 for this completion (miss completion). Then IDLE.
- mem_req, mem_we, mem_addr, mem_wdata are registered and stable while mem_req=1 and mem_ack=0. mem_ack while mem_req=0 is ignored.
- Miss latency with zero-wait memory (ack in the cycle after req): 2 + BLK_WORDS*(1+dirty) cycles minimum.
- Asserting rstn low in any state aborts immediately. mem_req drops asynchronously, the partial block is discarded, and the cache is empty afterwards.
- Boundaries: WAYS=1 behaves as direct-mapped with the fifo_ptr unused. A FIFO pointer wraps from WAYS-1 to 0.

Optional Feature:
CACHE_PERF_CNT_EN: when defined, adds three 32-bit outputs hit_cnt, miss_cnt and wb_cnt. Each counter:
- increments once per hit completion, miss completion, or WB block respectively;
- saturates at 0xFFFFFFFF;
- resets to 0 on rstn.
When not defined, these ports and their counters do not exist, and the remaining behaviour is identical.

Test Plan:
Configuration for all scenarios: ADDR_W=8, WAYS=2, SETS=4, BLK_WORDS=2, memory mem[a]=a+0x100 with ack 1 cycle after req.
1. Read 0x10 after reset -> mem reads 0x10,0x11, then cpu_rdata=0x110, hit=0. Then read 0x11 -> cpu_ready 1 cycle after acceptance, rdata=0x111, hit=1, no mem_req.
2. Write 0x10=0xDEADBEEF (hit), read 0x30 (fills way1), read 0x50 -> evicts way0: mem writes 0x10=0xDEADBEEF and 0x11=0x111, then reads 0x50,0x51; rdata=0x150.
3. Write miss 0x20=0x12345678 -> refill 0x20,0x21 with no memory write. Then read 0x20 -> hit=1, rdata=0x12345678. Read 0x21 -> 0x121.
4. Refill with mem_ack held low 5 cycles -> mem_req/mem_addr stable all 5 cycles, cpu_ready=0 until data returns.
5. rstn pulsed low during REFILL second word -> mem_req=0 at once. Re-read the same address -> miss and full refill.
6. With CACHE_PERF_CNT_EN, run scenarios 1-2 -> hit_cnt=2, miss_cnt=3, wb_cnt=1.
